// File: rtl/uart_pkg.sv
// Shared UART transmit-side types and default sizing for the tx byte buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_RDY
  } tx_fifo_state_t;

  localparam int unsigned UART_TX_FIFO_DEPTH  = 16;
  localparam int unsigned UART_TX_FIFO_THRESH = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte store with separate occupancy count; decides accept/drop for
// each write strobe.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       pop,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a full buffer still takes the write.
  assign w_push  = wr_en && (!full || w_pop);
  assign drop    = wr_en && !w_push;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues processor bytes and paces them to the UART by tx_rdy.
// Optional low-watermark pulse on fifo_int enabled by UART_TX_FIFO_LOWMARK_INT_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int unsigned THRESH = UART_TX_FIFO_THRESH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       ovf_clr,
  input  logic                       tx_rdy,
  output logic                       load,
  output logic [7:0]                 out_port,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       fifo_int
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || THRESH >= DEPTH) begin : g_param_check
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2 and THRESH below DEPTH");
  end

  tx_fifo_state_t r_state;
  logic           r_load;
  logic [7:0]     r_out_port;
  logic           r_overflow;
  logic           w_pop;
  logic           w_drop;
  logic           w_empty;
  logic [7:0]     w_rd_data;
  logic [CW-1:0]  w_count;

  assign w_pop = (r_state == IDLE) && !w_empty && tx_rdy;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (w_pop),
    .rd_data (w_rd_data),
    .count   (w_count),
    .full    (full),
    .empty   (w_empty),
    .drop    (w_drop)
  );

  // load is registered alongside the state so it is high exactly while in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_load     <= 1'b0;
      r_out_port <= '0;
    end else begin
      r_load <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_out_port <= w_rd_data;
            r_load     <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD:      r_state <= WAIT_BUSY;
        WAIT_BUSY: if (!tx_rdy) r_state <= WAIT_RDY;
        WAIT_RDY:  if (tx_rdy)  r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

`ifdef UART_TX_FIFO_LOWMARK_INT_EN
  logic r_fifo_int;

  // Pop-only cycle leaving THRESH+1 lands exactly on THRESH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fifo_int <= 1'b0;
    else        r_fifo_int <= w_pop && !(wr_en && !w_drop) && (w_count == CW'(THRESH + 1));
  end

  assign fifo_int = r_fifo_int;
`else
  assign fifo_int = 1'b0;
`endif

  assign load     = r_load;
  assign out_port = r_out_port;
  assign empty    = w_empty;
  assign count    = w_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic
// against a queue-based reference model and a simple UART busy model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          ovf_clr = 1'b0;
  logic          tx_rdy = 1'b0;
  logic          load;
  logic [7:0]    out_port;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          fifo_int;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  int         busy = 0;
  int         busy_len = 3;
  logic       rdy_block = 1'b0;
  logic       prev_rdy = 1'b0;
  logic       prev_load = 1'b0;
  logic       check_gap = 1'b0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         last_load_cyc = 0;
  int         loads = 0;
  int         ints = 0;
  logic [7:0] last_out = '0;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .tx_rdy   (tx_rdy),
    .load     (load),
    .out_port (out_port),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .fifo_int (fifo_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic step(input logic wr, input logic [7:0] d, input logic clr);
    int   sz;
    logic popped;
    logic acc;
    logic exp_int;
    logic [7:0] exp_b;
    wr_en   = wr;
    wr_data = d;
    ovf_clr = clr;
    tx_rdy  = !rdy_block && (busy == 0);
    if (tx_rdy && !prev_rdy) rise_cyc = cyc;
    prev_rdy = tx_rdy;
    @(posedge clk);
    sz = q.size();
    @(negedge clk);
    cyc++;
    popped  = load;
    acc     = wr && (sz < DEPTH || popped);
    exp_int = 1'b0;
    if (popped) begin
      chk("load_with_data", 32'(sz != 0), 1);
      chk("load_one_cycle", 32'(prev_load), 0);
      if (q.size() != 0) begin
        exp_b = q.pop_front();
        chk("out_port", out_port, exp_b);
      end
      if (check_gap && rise_cyc > last_load_cyc)
        chk("pace_gap_ge2", 32'((cyc - rise_cyc) >= 2), 1);
`ifdef UART_TX_FIFO_LOWMARK_INT_EN
      exp_int = !acc && (sz == THRESH + 1);
`endif
      busy          = busy_len;
      loads++;
      last_load_cyc = cyc;
      last_out      = out_port;
    end else if (busy > 0) begin
      busy--;
    end
    if (acc) q.push_back(d);
    if (wr && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    chk("count", count, q.size());
    chk("empty", empty, 32'(q.size() == 0));
    chk("full", full, 32'(q.size() == DEPTH));
    chk("overflow", overflow, m_ovf);
    chk("fifo_int", fifo_int, exp_int);
    if (fifo_int) ints++;
    prev_load = load;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_load", load, 0);
    chk("rst_out_port", out_port, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_int", fifo_int, 0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    prev_load = 1'b0;
  endtask

  task automatic drain(input int max_steps);
    int n = 0;
    while ((q.size() != 0 || busy != 0) && n < max_steps) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int l0;
    int i0;
    async_reset();
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // Single byte latency: stored at N, load high after N+1.
    step(1'b1, 8'hA5, 1'b0);
    chk("single_no_load_yet", load, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_load", load, 1);
    chk("single_data", out_port, 8'hA5);
    drain(50);

    // Pacing with a long UART frame.
    busy_len  = 100;
    check_gap = 1'b1;
    l0        = loads;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    drain(1000);
    chk("pace_loads", loads - l0, 3);
    chk("pace_last", last_out, 8'h03);
    check_gap = 1'b0;

    // Overflow with the UART held not-ready.
    busy_len  = 4;
    rdy_block = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // Full buffer: write accepted in the same cycle as the pop.
    rdy_block = 1'b0;
    l0        = loads;
    step(1'b1, 8'hEE, 1'b0);
    chk("fullpop_load", load, 1);
    chk("fullpop_count", count, DEPTH);
    chk("fullpop_ovf", overflow, 0);
    drain(2000);
    chk("fullpop_loads", loads - l0, DEPTH + 1);
    chk("fullpop_ee_last", last_out, 8'hEE);

    // Low-watermark: fill to 8, drain.
    rdy_block = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    i0        = ints;
    rdy_block = 1'b0;
    drain(500);
`ifdef UART_TX_FIFO_LOWMARK_INT_EN
    chk("lowmark_pulses", ints - i0, 1);
`else
    chk("lowmark_pulses", ints - i0, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) rdy_block = !rdy_block;
      if ($urandom_range(0, 9) == 0) busy_len = $urandom_range(1, 6);
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 15) == 0);
    end
    rdy_block = 1'b0;
    busy_len  = 3;
    drain(2000);

    // Reset mid-frame with five bytes still queued.
    busy_len  = 50;
    rdy_block = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    rdy_block = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("midframe_queued", count, 5);
    async_reset();
    repeat (5) step(1'b0, 8'h00, 1'b0);
    l0 = loads;
    step(1'b1, 8'h3C, 1'b0);
    drain(300);
    chk("post_reset_loads", loads - l0, 1);
    chk("post_reset_data", last_out, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
